// File: rtl/traffic_light.sv
// Two-way (NS/EW) intersection controller: Moore FSM NS_G -> NS_Y -> EW_G -> EW_Y, phases timed in tick pulses.
// Latency: lamp change is visible right after the clock edge that samples the terminal tick (0 extra cycles).
// Backpressure: none; tick is a free-running enable, each high cycle counts as one tick (no edge detect).
//
// Ports:
//   clk  - system clock, rising edge
//   rst  - synchronous active-high reset, forces NS green with a cleared phase counter
//   tick - time-unit enable from an external prescaler
//   ns_g/ns_y/ns_r, ew_g/ew_y/ew_r - lamp outputs, decoded only from the state register
module traffic_light #(
    parameter int NS_GREEN_TICKS  = 5,
    parameter int NS_YELLOW_TICKS = 2,
    parameter int EW_GREEN_TICKS  = 5,
    parameter int EW_YELLOW_TICKS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    output logic ns_g,
    output logic ns_y,
    output logic ns_r,
    output logic ew_g,
    output logic ew_y,
    output logic ew_r
);

    localparam int MAX_NS = (NS_GREEN_TICKS > NS_YELLOW_TICKS) ? NS_GREEN_TICKS : NS_YELLOW_TICKS;
    localparam int MAX_EW = (EW_GREEN_TICKS > EW_YELLOW_TICKS) ? EW_GREEN_TICKS : EW_YELLOW_TICKS;
    localparam int MAX_D  = (MAX_NS > MAX_EW) ? MAX_NS : MAX_EW;
    // cnt only ever holds 0..DUR-1, so clog2 of the longest phase is enough.
    localparam int CW     = (MAX_D > 1) ? $clog2(MAX_D) : 1;

    localparam logic [CW-1:0] NSG_LAST = CW'(NS_GREEN_TICKS - 1);
    localparam logic [CW-1:0] NSY_LAST = CW'(NS_YELLOW_TICKS - 1);
    localparam logic [CW-1:0] EWG_LAST = CW'(EW_GREEN_TICKS - 1);
    localparam logic [CW-1:0] EWY_LAST = CW'(EW_YELLOW_TICKS - 1);

    localparam logic [1:0] S_NS_G = 2'd0;
    localparam logic [1:0] S_NS_Y = 2'd1;
    localparam logic [1:0] S_EW_G = 2'd2;
    localparam logic [1:0] S_EW_Y = 2'd3;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] last_cnt;

    // Per-state terminal count and successor. The default arm treats any
    // unexpected encoding as NS yellow so the controller falls back into
    // the normal sequence on the next terminal tick.
    always_comb begin
        last_cnt  = NSY_LAST;
        state_nxt = S_EW_G;
        case (state)
            S_NS_G: begin
                last_cnt  = NSG_LAST;
                state_nxt = S_NS_Y;
            end
            S_NS_Y: begin
                last_cnt  = NSY_LAST;
                state_nxt = S_EW_G;
            end
            S_EW_G: begin
                last_cnt  = EWG_LAST;
                state_nxt = S_EW_Y;
            end
            S_EW_Y: begin
                last_cnt  = EWY_LAST;
                state_nxt = S_NS_G;
            end
            default: begin
                last_cnt  = NSY_LAST;
                state_nxt = S_EW_G;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_NS_G;
            cnt   <= '0;
        end else if (tick) begin
            if (cnt == last_cnt) begin
                state <= state_nxt;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Moore decode: exactly one lamp per direction, and the crossing
    // direction is red whenever the other shows green or yellow.
    always_comb begin
        ns_g = 1'b0;
        ns_y = 1'b0;
        ns_r = 1'b0;
        ew_g = 1'b0;
        ew_y = 1'b0;
        ew_r = 1'b0;
        case (state)
            S_NS_G: begin
                ns_g = 1'b1;
                ew_r = 1'b1;
            end
            S_NS_Y: begin
                ns_y = 1'b1;
                ew_r = 1'b1;
            end
            S_EW_G: begin
                ew_g = 1'b1;
                ns_r = 1'b1;
            end
            S_EW_Y: begin
                ew_y = 1'b1;
                ns_r = 1'b1;
            end
            default: begin
                ns_y = 1'b1;
                ew_r = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_traffic_light.sv
// Bench for traffic_light: directed steps plus random tick/reset traffic, checked
// every cycle against a tick-count model (ticks since reset, modulo the full cycle).
// Lamp vectors are packed {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r}.
module tb_traffic_light;

    localparam int NSG   = 5;
    localparam int NSY   = 2;
    localparam int EWG   = 5;
    localparam int EWY   = 2;
    localparam int TOTAL = NSG + NSY + EWG + EWY;

    localparam logic [5:0] L_NS_G = 6'b100001;
    localparam logic [5:0] L_NS_Y = 6'b010001;
    localparam logic [5:0] L_EW_G = 6'b001100;
    localparam logic [5:0] L_EW_Y = 6'b001010;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic tick = 1'b0;
    logic ns_g, ns_y, ns_r, ew_g, ew_y, ew_r;

    int n_cmp = 0;
    int n_bad = 0;
    int ticks_since_rst = 0;

    traffic_light #(
        .NS_GREEN_TICKS (NSG),
        .NS_YELLOW_TICKS(NSY),
        .EW_GREEN_TICKS (EWG),
        .EW_YELLOW_TICKS(EWY)
    ) dut (
        .clk (clk),
        .rst (rst),
        .tick(tick),
        .ns_g(ns_g),
        .ns_y(ns_y),
        .ns_r(ns_r),
        .ew_g(ew_g),
        .ew_y(ew_y),
        .ew_r(ew_r)
    );

    always #5 clk = ~clk;

    // Expected lamps from the number of ticks counted since the last reset.
    function automatic logic [5:0] model_lamps(input int n);
        int p;
        p = n % TOTAL;
        if (p < NSG)                   return L_NS_G;
        else if (p < NSG + NSY)        return L_NS_Y;
        else if (p < NSG + NSY + EWG)  return L_EW_G;
        else                           return L_EW_Y;
    endfunction

    function automatic logic [5:0] lamps();
        return {ns_g, ns_y, ns_r, ew_g, ew_y, ew_r};
    endfunction

    task automatic check_model(input string tag);
        logic [5:0] obs;
        logic [5:0] exp;
        obs = lamps();
        exp = model_lamps(ticks_since_rst);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: lamps %b expected %b (ticks=%0d)", tag, obs, exp, ticks_since_rst);
        end
        n_cmp++;
        assert (($countones(obs[5:3]) == 1) && ($countones(obs[2:0]) == 1)
                && (((obs[5] | obs[4]) & (obs[2] | obs[1])) == 1'b0)) else begin
            n_bad++;
            $error("FAIL %s_onehot: lamps %b expected one lamp per direction, no overlap", tag, obs);
        end
    endtask

    task automatic expect_lamps(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = lamps();
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: lamps %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, check #1 later.
    task automatic step(input logic r, input logic t);
        rst  = r;
        tick = t;
        @(posedge clk);
        if (r)      ticks_since_rst = 0;
        else if (t) ticks_since_rst++;
        #1;
        check_model("cycle");
    endtask

    // One tick pulse followed by idle clocks, period p clocks.
    task automatic tick_period(input int p);
        step(1'b0, 1'b1);
        for (int i = 1; i < p; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        // Reset held with tick toggling.
        for (int i = 0; i < 5; i++) step(1'b1, 1'(i % 2));
        expect_lamps("reset_hold", L_NS_G);

        // Released, no ticks: nothing moves.
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
        expect_lamps("idle_after_reset", L_NS_G);

        // Full cycle, tick every 5 clocks.
        for (int k = 1; k <= TOTAL; k++) begin
            tick_period(5);
            if (k == 4)  expect_lamps("tick4_ns_g", L_NS_G);
            if (k == 5)  expect_lamps("tick5_ns_y", L_NS_Y);
            if (k == 7)  expect_lamps("tick7_ew_g", L_EW_G);
            if (k == 12) expect_lamps("tick12_ew_y", L_EW_Y);
            if (k == 14) expect_lamps("tick14_ns_g", L_NS_G);
        end

        // Continue to 60 ticks with random tick spacing.
        for (int k = TOTAL + 1; k <= 60; k++) tick_period(int'($urandom_range(1, 4)));
        expect_lamps("tick60_ns_g", L_NS_G);  // 60 % 14 = 4 -> NS green

        // Mid-phase reset after 3 ticks of EW green.
        step(1'b1, 1'b0);
        for (int k = 0; k < NSG + NSY + 3; k++) tick_period(2);
        expect_lamps("ew_g_mid", L_EW_G);
        step(1'b1, 1'b0);
        expect_lamps("mid_reset", L_NS_G);
        for (int k = 0; k < NSG - 1; k++) tick_period(3);
        expect_lamps("post_reset_ns_g_4", L_NS_G);
        tick_period(3);
        expect_lamps("post_reset_ns_y", L_NS_Y);

        // Tick held high: each clock is a tick.
        step(1'b1, 1'b0);
        for (int k = 0; k < NSG - 1; k++) step(1'b0, 1'b1);
        expect_lamps("cont_tick_ns_g", L_NS_G);
        step(1'b0, 1'b1);
        expect_lamps("cont_tick_ns_y", L_NS_Y);
        for (int k = 0; k < NSY; k++) step(1'b0, 1'b1);
        expect_lamps("cont_tick_ew_g", L_EW_G);

        // Tick and reset together: reset wins with a cleared counter.
        step(1'b1, 1'b1);
        expect_lamps("rst_and_tick", L_NS_G);
        for (int k = 0; k < NSG - 1; k++) step(1'b0, 1'b1);
        expect_lamps("rst_tick_cnt0_ns_g", L_NS_G);
        step(1'b0, 1'b1);
        expect_lamps("rst_tick_cnt0_ns_y", L_NS_Y);

        // Random tick density with occasional resets, model-checked every cycle.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/traffic_light.md
# traffic_light

Tick-driven two-way intersection controller (north-south / east-west) producing one-hot green/yellow/red lamp outputs for each direction. A Moore FSM cycles NS green → NS yellow → EW green → EW yellow with phase durations counted in `tick` pulses. `tick` comes from an external prescaler, e.g. a 1 Hz enable, so the block itself is clock-rate independent.

## Interface
Parameters:
- `NS_GREEN_TICKS`, default 5: ticks spent in NS green (≥1).
- `NS_YELLOW_TICKS`, default 2: ticks spent in NS yellow (≥1).
- `EW_GREEN_TICKS`, default 5: ticks spent in EW green (≥1).
- `EW_YELLOW_TICKS`, default 2: ticks spent in EW yellow (≥1).

Ports:
- `clk` input 1: single system clock; all state updates on its rising edge.
- `rst` input 1: reset; one clock, reset is synchronous and active-high.
- `tick` input 1: single-cycle enable pulse, one per time unit; sampled on `clk` rising edge.
- `ns_g` output 1: NS green lamp.
- `ns_y` output 1: NS yellow lamp.
- `ns_r` output 1: NS red lamp.
- `ew_g` output 1: EW green lamp.
- `ew_y` output 1: EW yellow lamp.
- `ew_r` output 1: EW red lamp.

## Operation
- States:
  - S_NS_G: ns_g=1, ew_r=1.
  - S_NS_Y: ns_y=1, ew_r=1.
  - S_EW_G: ew_g=1, ns_r=1.
  - S_EW_Y: ew_y=1, ns_r=1.
  - All other lamp outputs are 0 in each state.
- Transition order: S_NS_G → S_NS_Y → S_EW_G → S_EW_Y → S_NS_G, repeating forever.
- Phase counter `cnt`:
  - Width is `$clog2` of the largest duration parameter, minimum 1 bit.
  - Counts ticks elapsed in the current state.
- Each rising edge, in priority order:
  1. `rst`=1: state ← S_NS_G, cnt ← 0.
  2. Else `tick`=0: state and cnt hold.
  3. Else `tick`=1 and cnt == DUR(state)−1: state ← next state, cnt ← 0.
  4. Else `tick`=1: cnt ← cnt+1.
- Outputs are a pure decode of the state register (Moore); no combinational path from `tick` or `rst`.
- Invariants, every cycle:
  - Each direction has exactly one lamp lit.
  - ns_r and ew_r are never both 0, so greens/yellows never overlap between directions.
- State encoding is free.
- Unreachable encodings decode to S_NS_Y lamp values (ns_y=1, ew_r=1) and transition to S_EW_G on the next tick, so the block recovers.
- Tick pulses wider than one cycle are counted once per high cycle; the FSM does not edge-detect.

## Timing
- Reset value of outputs (visible in the cycle after the reset edge, and held while `rst`=1):
  - ns_g=1, ns_y=0, ns_r=0.
  - ew_g=0, ew_y=0, ew_r=1.
- A state change becomes visible on outputs immediately after the clock edge that samples the terminal `tick`.
- Latency from terminal tick to lamp change: 0 extra cycles.
- Phase lengths in ticks: NS green 5, NS yellow 2, EW green 5, EW yellow 2. Full cycle is 14 ticks.
- With tick every P clocks, a phase of D ticks lasts D×P clocks, measured from the first tick edge after state entry.
  - Exception: the first NS green after reset starts counting at the first tick after reset release.
- `rst` mid-phase: the next edge forces S_NS_G with cnt=0, regardless of `tick` in the same cycle.
- `tick` and `rst` both high: reset wins.
- Duration of 1: state advances on every tick.

## Test plan
- Reset check: hold `rst`=1 for 5 cycles with `tick` toggling → outputs stay {ns_g, ew_r}=1, all else 0. Release; no ticks for 20 cycles → outputs unchanged.
- Full cycle, tick every 5 clocks (1-cycle pulse):
  - After 5 ticks → ns_y=1, ew_r=1.
  - After 7 ticks → ew_g=1, ns_r=1.
  - After 12 ticks → ew_y=1, ns_r=1.
  - After 14 ticks → back to ns_g=1, ew_r=1.
- Multiple periods: run 60 ticks → sequence repeats with period 14 ticks.
- One-hot check: every cycle, each direction has exactly one lamp lit; (ns_g|ns_y) & (ew_g|ew_y) is always 0.
- Mid-phase reset: assert `rst` for 1 cycle while in S_EW_G after 3 of its ticks → next cycle ns_g=1, ew_r=1. NS green then lasts a full 5 ticks.
- Boundaries:
  - `tick` held high continuously → state advances per clock-counted tick; NS green lasts 5 clocks.
  - `tick` and `rst` asserted simultaneously → reset state with cnt=0.
